vrrm_fl: RTL and testbench
==========================

VRRM_FL -- requirements
Module: vrrm_fl

Interface
REQ-001 SHALL have parameter VECTOR_REGISTERS, default 32: architectural vector registers (power of 2).
REQ-002 SHALL have parameter PHYS_REGISTERS, default 48: physical vector registers, greater than VECTOR_REGISTERS.
REQ-003 SHALL have parameter VECTOR_TICKET_BITS, default 4: ticket width; ticket 0 reserved as "none".
REQ-004 SHALL define derived widths: AW=$clog2(VECTOR_REGISTERS), PW=$clog2(PHYS_REGISTERS), FL_DEPTH=PHYS_REGISTERS-VECTOR_REGISTERS.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input instruction valid.
- ready_o  out  1  input accepted (pop) this cycle.
- dst_i, src1_i, src2_i  in  AW each  architectural registers.
- writes_dst_i  in  1  instruction writes dst; a store or reconfig drives 0.
- reconfig_i  in  1  reconfiguration instruction.
- valid_o  out  1  output stage valid.
- ready_i  in  1  downstream ready.
- pdst_o, psrc1_o, psrc2_o, old_pdst_o  out  PW each  physical mappings; old_pdst_o is the previous mapping of dst_i.
- dst_iszero_o  out  1  registered ~writes_dst_i.
- reconfig_o  out  1  registered reconfig_i.
- ticket_o  out  VECTOR_TICKET_BITS  instruction ticket.
- last_ticket_src1_o, last_ticket_src2_o  out  VECTOR_TICKET_BITS  ticket of the last producer of the source, 0 if none.
- rel_valid_i  in  1  release a physical register to the free list.
- rel_preg_i  in  PW  physical register released.
- fl_count_o  out  PW+1  free-list occupancy.
- is_idle_o  out  1  ~valid_i & ~valid_o.

Function
REQ-006 SHALL accept (acc) when valid_i & ready_o.
- ready_o = (~valid_o | ready_i) & (~writes_dst_i | fl_count_o!=0).
- ready_o is combinational and has no dependence on valid_i.
REQ-007 SHALL register all outputs in a single stage: acc in cycle N gives valid_o=1 in N+1. Outputs hold stable while valid_o & ~ready_i. valid_o clears on ready_i & ~acc.
REQ-008 SHALL read psrc1/psrc2/old_pdst from the RAT before the same instruction's dst update. For src==dst the result is the old mapping.
REQ-009 on acc with writes_dst_i SHALL:
- pop the free-list head into pdst_o;
- write RAT[dst_i]=head;
- set last_producer[dst_i]=current ticket.
REQ-010 on acc with ~writes_dst_i SHALL:
- leave the free list, RAT and last_producer unchanged;
- set pdst_o to the current RAT[dst_i].
REQ-011 SHALL implement the free list as a circular FIFO of depth FL_DEPTH with head/tail pointers that wrap at FL_DEPTH-1 to 0.
REQ-012 SHALL push rel_preg_i at the tail when rel_valid_i. A simultaneous push and pop leaves the count unchanged.
REQ-013 SHALL NOT bypass a release to an allocation in the same cycle: an allocation with the list empty stalls even if rel_valid_i=1.
REQ-014 SHALL ignore rel_valid_i when fl_count_o==FL_DEPTH; an SVA flags this as an error.
REQ-015 SHALL assign each accepted instruction the current ticket.
- The counter increments per acc and wraps 2^VECTOR_TICKET_BITS-1 to 1.
- 0 is never issued.
REQ-016 SHALL output last_ticket_srcX_o = last_producer[srcX_i], read before the update.
REQ-017 on acc of reconfig_i, the instruction itself SHALL:
- receive the current ticket;
- receive identity mappings.
REQ-018 on acc of reconfig_i, in the next cycle the block SHALL:
- reset the RAT to identity (i maps to i);
- reset last_producer to 0 and ticket to 1;
- refill the free list with VECTOR_REGISTERS..PHYS_REGISTERS-1 in order, with fl_count=FL_DEPTH;
- drop any release in the same cycle.

Reset
REQ-019 SHALL, while rst_n=0, hold the state REQ-018 sets (identity RAT, refilled free list, ticket 1, last_producer 0) and drive valid_o=0, all data outputs 0, fl_count_o=FL_DEPTH, is_idle_o=~valid_i.
REQ-020 SHALL discard an in-flight output on assertion of rst_n=0 mid-operation, with no partial RAT or free-list update.

Verification
REQ-021 With defaults after reset, instr dst=3 src1=3 src2=5 writes=1 -> next cycle:
- valid_o=1, pdst=32, psrc1=3, psrc2=5, old_pdst=3;
- ticket=1, last tickets 0, fl_count=15.
REQ-022 16 accepted allocating instrs, no release -> 17th sees ready_o=0. rel 3 -> one cycle later ready_o=1 and the 17th gets pdst=3.
REQ-023 ready_i=0 for 5 cycles with valid_o=1 -> outputs stable, ready_o=0, no free-list or ticket change.
REQ-024 16 accepted instrs -> tickets 1..15 then 1. Second writer of v4 after the first (ticket 2) -> a reader of v4 gets last_ticket=2.
REQ-025 Remap several registers, then accept reconfig -> next instr dst=7 src1=7 gets psrc1=7, pdst=32, ticket=1, fl_count=15.
REQ-026 rst_n=0 asserted while valid_o=1 with fl_count=10 -> valid_o=0 and fl_count=16 immediately, and the first post-reset instr gets pdst=32.

Source files
------------

// File: rtl/vrrm_fl.sv
// Vector register rename stage: RAT lookup, free-list allocation, producer
// ticket tracking and a single registered output stage.
module vrrm_fl #(
   parameter  int unsigned VECTOR_REGISTERS   = 32,
   parameter  int unsigned PHYS_REGISTERS     = 48,
   parameter  int unsigned VECTOR_TICKET_BITS = 4,
   localparam int unsigned AW       = $clog2(VECTOR_REGISTERS),
   localparam int unsigned PW       = $clog2(PHYS_REGISTERS),
   localparam int unsigned FL_DEPTH = PHYS_REGISTERS - VECTOR_REGISTERS,
   localparam int unsigned TW       = VECTOR_TICKET_BITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [AW-1:0] dst_i,
   input  logic [AW-1:0] src1_i,
   input  logic [AW-1:0] src2_i,
   input  logic          writes_dst_i,
   input  logic          reconfig_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [PW-1:0] pdst_o,
   output logic [PW-1:0] psrc1_o,
   output logic [PW-1:0] psrc2_o,
   output logic [PW-1:0] old_pdst_o,
   output logic          dst_iszero_o,
   output logic          reconfig_o,
   output logic [TW-1:0] ticket_o,
   output logic [TW-1:0] last_ticket_src1_o,
   output logic [TW-1:0] last_ticket_src2_o,
   input  logic          rel_valid_i,
   input  logic [PW-1:0] rel_preg_i,
   output logic [PW:0]   fl_count_o,
   output logic          is_idle_o
);

   localparam int unsigned FLW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
   localparam int unsigned CW  = PW + 1;

   logic [PW-1:0]  rat_q [VECTOR_REGISTERS];
   logic [TW-1:0]  lp_q  [VECTOR_REGISTERS];
   logic [PW-1:0]  fl_q  [FL_DEPTH];
   logic [FLW-1:0] head_q, tail_q;
   logic [CW-1:0]  count_q;
   logic [TW-1:0]  ticket_q;

   logic           acc, alloc, reconf, push, fl_full;
   logic [FLW-1:0] head_inc, tail_inc;
   logic [TW-1:0]  ticket_nxt;
   logic [CW-1:0]  count_nxt;

   // Handshake, free-list push/pop decisions and pointer/ticket increments
   always_comb begin
      ready_o    = (~valid_o | ready_i) & (~writes_dst_i | (count_q != '0));
      acc        = valid_i & ready_o;
      reconf     = acc & reconfig_i;
      alloc      = acc & writes_dst_i & ~reconfig_i;
      fl_full    = (count_q == CW'(FL_DEPTH));
      // Releases never bypass to an allocation: ready_o only sees count_q.
      push       = rel_valid_i & ~fl_full & ~reconf;
      head_inc   = (head_q == FLW'(FL_DEPTH - 1)) ? '0 : head_q + FLW'(1);
      tail_inc   = (tail_q == FLW'(FL_DEPTH - 1)) ? '0 : tail_q + FLW'(1);
      ticket_nxt = (ticket_q == '1) ? TW'(1) : ticket_q + TW'(1);
      count_nxt  = count_q + CW'(push) - CW'(alloc);
   end

   // Rename state: RAT, last producer, free list and ticket counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < VECTOR_REGISTERS; i++) begin
            rat_q[i] <= PW'(i);
            lp_q[i]  <= '0;
         end
         for (int unsigned i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(VECTOR_REGISTERS + i);
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= CW'(FL_DEPTH);
         ticket_q <= TW'(1);
      end else if (reconf) begin
         for (int unsigned i = 0; i < VECTOR_REGISTERS; i++) begin
            rat_q[i] <= PW'(i);
            lp_q[i]  <= '0;
         end
         for (int unsigned i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(VECTOR_REGISTERS + i);
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= CW'(FL_DEPTH);
         ticket_q <= TW'(1);
      end else begin
         if (alloc) begin
            rat_q[dst_i] <= fl_q[head_q];
            lp_q[dst_i]  <= ticket_q;
            head_q       <= head_inc;
         end
         if (push) begin
            fl_q[tail_q] <= rel_preg_i;
            tail_q       <= tail_inc;
         end
         count_q <= count_nxt;
         if (acc) ticket_q <= ticket_nxt;
      end
   end

   // Output stage: load on accept, hold while stalled, drain on ready_i
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o            <= 1'b0;
         pdst_o             <= '0;
         psrc1_o            <= '0;
         psrc2_o            <= '0;
         old_pdst_o         <= '0;
         dst_iszero_o       <= 1'b0;
         reconfig_o         <= 1'b0;
         ticket_o           <= '0;
         last_ticket_src1_o <= '0;
         last_ticket_src2_o <= '0;
      end else if (acc) begin
         valid_o            <= 1'b1;
         dst_iszero_o       <= ~writes_dst_i;
         reconfig_o         <= reconfig_i;
         ticket_o           <= ticket_q;
         last_ticket_src1_o <= lp_q[src1_i];
         last_ticket_src2_o <= lp_q[src2_i];
         if (reconfig_i) begin
            pdst_o     <= PW'(dst_i);
            psrc1_o    <= PW'(src1_i);
            psrc2_o    <= PW'(src2_i);
            old_pdst_o <= PW'(dst_i);
         end else begin
            pdst_o     <= alloc ? fl_q[head_q] : rat_q[dst_i];
            psrc1_o    <= rat_q[src1_i];
            psrc2_o    <= rat_q[src2_i];
            old_pdst_o <= rat_q[dst_i];
         end
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

   assign fl_count_o = count_q;
   assign is_idle_o  = ~valid_i & ~valid_o;

   // A release into a full free list indicates a bookkeeping error upstream
   a_no_rel_when_full: assert property (@(posedge clk) disable iff (!rst_n)
                                        !(rel_valid_i && fl_full));

endmodule

// File: tb/tb_vrrm_fl.sv
// Self-checking bench for vrrm_fl: reference rename model plus output scoreboard.
module tb_vrrm_fl;

   localparam int unsigned VR  = 32;
   localparam int unsigned PR  = 48;
   localparam int unsigned TB  = 4;
   localparam int unsigned AW  = 5;
   localparam int unsigned PW  = 6;
   localparam int unsigned FLD = PR - VR;

   logic          clk;
   logic          rst_n;
   logic          valid_i, ready_o, writes_dst_i, reconfig_i;
   logic [AW-1:0] dst_i, src1_i, src2_i;
   logic          valid_o, ready_i;
   logic [PW-1:0] pdst_o, psrc1_o, psrc2_o, old_pdst_o;
   logic          dst_iszero_o, reconfig_o;
   logic [TB-1:0] ticket_o, last_ticket_src1_o, last_ticket_src2_o;
   logic          rel_valid_i;
   logic [PW-1:0] rel_preg_i;
   logic [PW:0]   fl_count_o;
   logic          is_idle_o;

   vrrm_fl dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .dst_i(dst_i), .src1_i(src1_i), .src2_i(src2_i),
      .writes_dst_i(writes_dst_i), .reconfig_i(reconfig_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .pdst_o(pdst_o), .psrc1_o(psrc1_o), .psrc2_o(psrc2_o), .old_pdst_o(old_pdst_o),
      .dst_iszero_o(dst_iszero_o), .reconfig_o(reconfig_o), .ticket_o(ticket_o),
      .last_ticket_src1_o(last_ticket_src1_o), .last_ticket_src2_o(last_ticket_src2_o),
      .rel_valid_i(rel_valid_i), .rel_preg_i(rel_preg_i),
      .fl_count_o(fl_count_o), .is_idle_o(is_idle_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [PW-1:0] pdst;
      logic [PW-1:0] psrc1;
      logic [PW-1:0] psrc2;
      logic [PW-1:0] old_pdst;
      logic [TB-1:0] ticket;
      logic [TB-1:0] lt1;
      logic [TB-1:0] lt2;
      logic          iszero;
      logic          rc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_a, mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int rat[VR];
   int lp[VR];
   int tk;
   int fl[$];

   task automatic model_reset();
      for (int i = 0; i < VR; i++) begin
         rat[i] = i;
         lp[i]  = 0;
      end
      tk = 1;
      fl.delete();
      for (int i = 0; i < FLD; i++) fl.push_back(VR + i);
   endtask

   // Drive one instruction, wait (bounded) for acceptance, record expectation
   task automatic send(input int dst, input int s1, input int s2, input logic wr, input logic rc);
      exp_t e;
      bit   done;
      done         = 1'b0;
      dst_i        = AW'(dst);
      src1_i       = AW'(s1);
      src2_i       = AW'(s2);
      writes_dst_i = wr;
      reconfig_i   = rc;
      valid_i      = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         #1;
         if (ready_o) begin
            e.ticket = TB'(tk);
            e.lt1    = TB'(lp[s1]);
            e.lt2    = TB'(lp[s2]);
            e.iszero = ~wr;
            e.rc     = rc;
            if (rc) begin
               e.pdst = PW'(dst); e.psrc1 = PW'(s1); e.psrc2 = PW'(s2); e.old_pdst = PW'(dst);
               model_reset();
            end else begin
               e.psrc1    = PW'(rat[s1]);
               e.psrc2    = PW'(rat[s2]);
               e.old_pdst = PW'(rat[dst]);
               if (wr) begin
                  e.pdst   = PW'(fl.pop_front());
                  rat[dst] = int'(e.pdst);
                  lp[dst]  = tk;
               end else begin
                  e.pdst = PW'(rat[dst]);
               end
               tk = (tk == (1 << TB) - 1) ? 1 : tk + 1;
            end
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_accept: got ready_o=0 for 50 cycles, required acceptance (dst=%0d)", dst);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid_i = 1'b0; rel_valid_i = 1'b0; rel_preg_i = '0; ready_i = 1'b1;
      writes_dst_i = 1'b0; reconfig_i = 1'b0;
      dst_i = '0; src1_i = '0; src2_i = '0;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      model_reset();
      rst_n = 1'b1;
   endtask

   // Output monitor: every transfer (valid_o & ready_i) pops and compares
   initial forever begin
      @(negedge clk);
      if (rst_n && valid_o && ready_i) begin
         mon_a = {pdst_o, psrc1_o, psrc2_o, old_pdst_o, ticket_o,
                  last_ticket_src1_o, last_ticket_src2_o, dst_iszero_o, reconfig_o};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got output pdst=%0d, required no output", pdst_o);
         end else begin
            mon_e = sb.pop_front();
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL out_txn: got pdst=%0d ps1=%0d ps2=%0d old=%0d tk=%0d lt1=%0d lt2=%0d z=%0b rc=%0b, required pdst=%0d ps1=%0d ps2=%0d old=%0d tk=%0d lt1=%0d lt2=%0d z=%0b rc=%0b",
                        mon_a.pdst, mon_a.psrc1, mon_a.psrc2, mon_a.old_pdst, mon_a.ticket, mon_a.lt1, mon_a.lt2, mon_a.iszero, mon_a.rc,
                        mon_e.pdst, mon_e.psrc1, mon_e.psrc2, mon_e.old_pdst, mon_e.ticket, mon_e.lt1, mon_e.lt2, mon_e.iszero, mon_e.rc);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      valid_i = 1'b0; rel_valid_i = 1'b0; rel_preg_i = '0; ready_i = 1'b1;
      writes_dst_i = 1'b0; reconfig_i = 1'b0;
      dst_i = '0; src1_i = '0; src2_i = '0;
      @(posedge clk);
      #1;
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", valid_o); end
      checks++;
      if (fl_count_o !== 7'(FLD)) begin errors++; $display("FAIL reset_fl_count: got %0d required %0d", fl_count_o, FLD); end
      checks++;
      if ({pdst_o, psrc1_o, ticket_o} !== '0) begin errors++; $display("FAIL reset_data: got pdst=%0d psrc1=%0d ticket=%0d required 0", pdst_o, psrc1_o, ticket_o); end
      checks++;
      if (is_idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b required 1", is_idle_o); end
      valid_i = 1'b1;
      #1;
      checks++;
      if (is_idle_o !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %0b required 0", is_idle_o); end
      valid_i = 1'b0;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      send(3, 3, 5, 1'b1, 1'b0);
      checks++;
      if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b required 1", valid_o); end
      checks++;
      if (fl_count_o !== 7'd15) begin errors++; $display("FAIL basic_fl_count: got %0d required 15", fl_count_o); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) send(i % 8, i, i + 1, 1'b1, 1'b0);
      checks++;
      if (fl_count_o !== 7'd0) begin errors++; $display("FAIL full_count: got %0d required 0", fl_count_o); end
      dst_i = AW'(10); src1_i = AW'(11); src2_i = AW'(12);
      writes_dst_i = 1'b1; reconfig_i = 1'b0; valid_i = 1'b1;
      rel_valid_i = 1'b1; rel_preg_i = PW'(3);
      #1;
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL full_stall_no_bypass: got ready_o=%0b required 0", ready_o); end
      @(posedge clk);
      #1;
      rel_valid_i = 1'b0;
      fl.push_back(3);
      checks++;
      if (fl_count_o !== 7'd1) begin errors++; $display("FAIL full_after_rel_count: got %0d required 1", fl_count_o); end
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL full_after_rel_ready: got %0b required 1", ready_o); end
      send(10, 11, 12, 1'b1, 1'b0);
      checks++;
      if (pdst_o !== PW'(3)) begin errors++; $display("FAIL full_realloc_pdst: got %0d required 3", pdst_o); end
   endtask

   task automatic test_stall();
      do_reset();
      send(6, 1, 2, 1'b1, 1'b0);
      ready_i = 1'b0;
      dst_i = AW'(9); src1_i = AW'(6); src2_i = AW'(0);
      writes_dst_i = 1'b1; reconfig_i = 1'b0; valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d: got %0b required 0", i, ready_o); end
         checks++;
         if ({valid_o, pdst_o, ticket_o} !== {1'b1, sb[0].pdst, sb[0].ticket}) begin
            errors++;
            $display("FAIL stall_hold c%0d: got v=%0b pdst=%0d tk=%0d required v=1 pdst=%0d tk=%0d",
                     i, valid_o, pdst_o, ticket_o, sb[0].pdst, sb[0].ticket);
         end
         checks++;
         if (fl_count_o !== 7'(fl.size())) begin errors++; $display("FAIL stall_fl_count c%0d: got %0d required %0d", i, fl_count_o, fl.size()); end
         @(posedge clk);
         #1;
      end
      ready_i = 1'b1;
      send(9, 6, 0, 1'b1, 1'b0);
   endtask

   task automatic test_tickets();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i == 0)       send(1, 0, 0, 1'b1, 1'b0);
         else if (i == 1)  send(4, 1, 2, 1'b1, 1'b0);
         else if (i == 2)  send(5, 4, 4, 1'b0, 1'b0);
         else if (i == 9)  send(4, 4, 6, 1'b1, 1'b0);
         else if (i == 15) send(8, 3, 4, 1'b0, 1'b0);
         else              send(i, i + 10, 4, 1'b0, 1'b0);
         if (i == 2) begin
            checks++;
            if (last_ticket_src1_o !== TB'(2)) begin errors++; $display("FAIL ticket_reader_v4: got %0d required 2", last_ticket_src1_o); end
         end
      end
      checks++;
      if (ticket_o !== TB'(1)) begin errors++; $display("FAIL ticket_wrap: got %0d required 1", ticket_o); end
   endtask

   task automatic test_reconfig();
      do_reset();
      send(7, 0, 0, 1'b1, 1'b0);
      send(2, 7, 1, 1'b1, 1'b0);
      send(9, 2, 7, 1'b1, 1'b0);
      rel_valid_i = 1'b1;
      rel_preg_i  = PW'(32);
      send(7, 2, 9, 1'b0, 1'b1);
      rel_valid_i = 1'b0;
      checks++;
      if (fl_count_o !== 7'(FLD)) begin errors++; $display("FAIL reconfig_refill: got %0d required %0d", fl_count_o, FLD); end
      send(7, 7, 3, 1'b1, 1'b0);
      checks++;
      if ({pdst_o, psrc1_o, ticket_o} !== {PW'(32), PW'(7), TB'(1)}) begin
         errors++;
         $display("FAIL reconfig_next: got pdst=%0d psrc1=%0d tk=%0d required pdst=32 psrc1=7 tk=1", pdst_o, psrc1_o, ticket_o);
      end
      checks++;
      if (fl_count_o !== 7'd15) begin errors++; $display("FAIL reconfig_fl_count: got %0d required 15", fl_count_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 6; i++) send(i + 1, i, i, 1'b1, 1'b0);
      checks++;
      if ({valid_o, fl_count_o} !== {1'b1, 7'd10}) begin errors++; $display("FAIL mid_pre: got v=%0b cnt=%0d required v=1 cnt=10", valid_o, fl_count_o); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({valid_o, fl_count_o, pdst_o} !== {1'b0, 7'd16, PW'(0)}) begin
         errors++;
         $display("FAIL mid_reset: got v=%0b cnt=%0d pdst=%0d required v=0 cnt=16 pdst=0", valid_o, fl_count_o, pdst_o);
      end
      sb.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(0, 1, 2, 1'b1, 1'b0);
      checks++;
      if (pdst_o !== PW'(32)) begin errors++; $display("FAIL mid_post_pdst: got %0d required 32", pdst_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_stall();
      test_tickets();
      test_reconfig();
      test_reset_mid();
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL drain: got %0d pending outputs required 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
